// File: rtl/alu_op_sched_pkg.sv
// Shared constants for the ALU operation scheduler: unit select codes
// carried in FUN[3:2] and the scheduler FSM state encoding.
package alu_op_sched_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int NUM_UNITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // One-hot enable vector for a unit select code (bit index = unit code).
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] unit);
    logic [NUM_UNITS-1:0] v;
    v = '0;
    v[unit] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/alu_op_sched_rr_arb2.sv
// Two-way round-robin grant logic. When both requesters are valid the one
// that was not granted last wins; a lone requester always wins.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_gnt_id
);

  // Grant decode: tie broken against the last granted id.
  always_comb begin
    o_grant  = 2'b00;
    o_gnt_id = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_gnt_id = ~i_last;
      o_grant  = i_last ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_gnt_id = 1'b0;
      o_grant  = 2'b01;
    end else if (i_valid1) begin
      o_gnt_id = 1'b1;
      o_grant  = 2'b10;
    end
  end

endmodule

// File: rtl/alu_op_sched.sv
// Two-requester scheduler sharing one ALU datapath (arith/logic/cmp/shift).
// One operation in flight at a time: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
// Handshake rules: a command transfers on a rising edge where reqX_valid and
// reqX_ready are both high (ready is only ever high in IDLE, for the granted
// requester); a response transfers on a rising edge where resp_valid and
// resp_ready are both high, and resp_* hold stable until then.
module alu_op_sched
  import alu_op_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  output logic             arith_en,
  output logic             logic_en,
  output logic             cmp_en,
  output logic             shift_en,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_flag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_rr_last;
  logic                   r_id_q;
  logic [WIDTH-1:0]       r_alu_a;
  logic [WIDTH-1:0]       r_alu_b;
  logic [3:0]             r_alu_fun;
  logic [NUM_UNITS-1:0]   r_en;
  logic                   r_resp_valid;
  logic                   r_resp_id;
  logic [WIDTH-1:0]       r_resp_data;
  logic                   r_resp_flag;
  logic [CNT_W-1:0]       r_op_count;

  logic [1:0]             w_grant;
  logic                   w_gnt_id;
  logic                   w_hs;
  logic                   w_resp_hs;
  logic [WIDTH-1:0]       w_in_a;
  logic [WIDTH-1:0]       w_in_b;
  logic [3:0]             w_in_fun;
  logic [WIDTH-1:0]       w_sel_out;
  logic                   w_sel_flag;

  rr_arb2 u_arb (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_last   (r_rr_last),
    .o_grant  (w_grant),
    .o_gnt_id (w_gnt_id)
  );

  assign w_hs      = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_resp_hs = r_resp_valid && resp_ready;
  assign w_in_a    = w_gnt_id ? req1_a   : req0_a;
  assign w_in_b    = w_gnt_id ? req1_b   : req0_b;
  assign w_in_fun  = w_gnt_id ? req1_fun : req0_fun;

  // Result mux keyed on the latched unit select.
  always_comb begin
    w_sel_out  = arith_out;
    w_sel_flag = arith_flag;
    case (r_alu_fun[3:2])
      UNIT_ARITH: begin w_sel_out = arith_out; w_sel_flag = arith_flag; end
      UNIT_LOGIC: begin w_sel_out = logic_out; w_sel_flag = logic_flag; end
      UNIT_CMP:   begin w_sel_out = cmp_out;   w_sel_flag = cmp_flag;   end
      default:    begin w_sel_out = shift_out; w_sel_flag = shift_flag; end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rest) begin
    if (!rest) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: EXEC and CAPT are single cycles, RESP waits for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = CAPT;
      CAPT:    w_state_nxt = RESP;
      RESP:    if (w_resp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready only toward the granted requester while IDLE.
  always_comb begin
    req0_ready = (r_state == IDLE) && w_grant[0];
    req1_ready = (r_state == IDLE) && w_grant[1];
    busy       = (r_state != IDLE);
    dbg_state  = r_state;
  end

  // Datapath: latch command, pulse the unit enable, capture and hand back the result.
  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      r_rr_last    <= 1'b1;
      r_id_q       <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_fun    <= '0;
      r_en         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_flag  <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_alu_a   <= w_in_a;
            r_alu_b   <= w_in_b;
            r_alu_fun <= w_in_fun;
            r_id_q    <= w_gnt_id;
            r_rr_last <= w_gnt_id;
            r_en      <= unit_onehot(w_in_fun[3:2]);
          end
        end
        EXEC: begin
          r_en <= '0;
        end
        CAPT: begin
          r_resp_data  <= w_sel_out;
          r_resp_flag  <= w_sel_flag;
          r_resp_id    <= r_id_q;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (w_resp_hs) begin
            r_resp_valid <= 1'b0;
            r_op_count   <= r_op_count + CNT_W'(1);
          end
        end
        default: r_en <= '0;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_fun    = r_alu_fun;
  assign arith_en   = r_en[UNIT_ARITH];
  assign logic_en   = r_en[UNIT_LOGIC];
  assign cmp_en     = r_en[UNIT_CMP];
  assign shift_en   = r_en[UNIT_SHIFT];
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_flag  = r_resp_flag;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sched.sv
// Bench for alu_op_sched: behavioural ALU unit stubs plus a transaction-level
// reference model (grant choice, unit result, op counter).
module tb_alu_op_sched;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             rest = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]       req0_fun = '0, req1_fun = '0;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_fun;
  logic             arith_en, logic_en, cmp_en, shift_en;
  logic [WIDTH-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic             arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_flag;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int m_last  = 1;
  int m_count = 0;

  alu_op_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .rest(rest),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flag(resp_flag), .busy(busy), .op_count(op_count),
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clock = ~clock;

  // Behavioural unit function: returns {flag, result}.
  function automatic logic [16:0] unit_calc(input int unit, input logic [1:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        f;
    int          sh;
    r = '0; f = 1'b0; sh = int'(b[3:0]);
    case (unit)
      0: begin
        s = op[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        r = s[15:0]; f = s[16];
      end
      1: begin
        case (op)
          2'd0: r = a & b;
          2'd1: r = a | b;
          2'd2: r = a ^ b;
          default: r = ~a;
        endcase
        f = (r == 16'd0);
      end
      2: begin
        case (op)
          2'd0: f = (a != b);
          2'd1: f = (a == b);
          2'd2: f = (a > b);
          default: f = (a < b);
        endcase
        r = f ? {14'd0, op} : 16'd0;
      end
      default: begin
        case (op)
          2'd0: r = a << sh;
          2'd1: r = a >> sh;
          2'd2: r = 16'($signed(a) >>> sh);
          default: r = {a[7:0], a[15:8]};
        endcase
        f = (r == 16'd0);
      end
    endcase
    return {f, r};
  endfunction

  // ALU unit stubs: register result and flag in the cycle their enable is high.
  always @(posedge clock) begin
    if (arith_en) {arith_flag, arith_out} <= unit_calc(0, alu_fun[1:0], alu_a, alu_b);
    if (logic_en) {logic_flag, logic_out} <= unit_calc(1, alu_fun[1:0], alu_a, alu_b);
    if (cmp_en)   {cmp_flag, cmp_out}     <= unit_calc(2, alu_fun[1:0], alu_a, alu_b);
    if (shift_en) {shift_flag, shift_out} <= unit_calc(3, alu_fun[1:0], alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: one full operation, called at a falling edge while the DUT is IDLE.
  // delay = cycles resp_ready stays low in RESP; early = resp_ready high throughout;
  // hold = keep both valids asserted after the handshake.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                        input int delay, input bit early, input bit hold);
    int          win;
    logic [15:0] ea, eb;
    logic [3:0]  ef;
    logic [16:0] er;
    logic [3:0]  een;
    win = (v0 && v1) ? (1 - m_last) : (v0 ? 0 : 1);
    ea  = (win == 1) ? a1 : a0;
    eb  = (win == 1) ? b1 : b0;
    ef  = (win == 1) ? f1 : f0;
    er  = unit_calc(int'(ef[3:2]), ef[1:0], ea, eb);
    een = 4'd0;
    een[ef[3:2]] = 1'b1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
    resp_ready = early;
    #1;
    check("ready0_idle", req0_ready, win == 0);
    check("ready1_idle", req1_ready, win == 1);
    check("busy_idle", busy, 0);
    m_last = win;
    @(negedge clock);
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    check("en_exec", {shift_en, cmp_en, logic_en, arith_en}, een);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_fun", alu_fun, ef);
    check("busy_exec", busy, 1);
    #1;
    check("ready_exec", {req1_ready, req0_ready}, 0);
    @(negedge clock);
    check("en_capt", {shift_en, cmp_en, logic_en, arith_en}, 0);
    check("rv_capt", resp_valid, 0);
    check("ready_capt", {req1_ready, req0_ready}, 0);
    @(negedge clock);
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, win);
    check("resp_data", resp_data, er[15:0]);
    check("resp_flag", resp_flag, er[16]);
    if (!early) begin
      for (int d = 0; d < delay; d++) begin
        @(negedge clock);
        check("stall_valid", resp_valid, 1);
        check("stall_data", resp_data, er[15:0]);
        check("stall_ready", {req1_ready, req0_ready}, 0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clock);
    m_count = (m_count + 1) % 256;
    check("rv_done", resp_valid, 0);
    check("op_count", op_count, m_count);
    check("busy_done", busy, 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int v;
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_alu", {alu_a, alu_b}, 0);
    check("rst_fun", alu_fun, 0);
    check("rst_en", {shift_en, cmp_en, logic_en, arith_en}, 0);
    check("rst_resp", {resp_valid, resp_id, resp_flag, resp_data}, 0);
    check("rst_count", op_count, 0);
    check("rst_busy", busy, 0);
    rest = 1'b1;
    m_last = 1; m_count = 0;
    @(negedge clock);

    // req0 alone, compare-equal
    run_op(1, 0, 16'd5, 16'd5, 4'b1001, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    check("cmp_eq_data", resp_data, 16'd1);

    // req1 compare A<B with response stall of 5 cycles
    run_op(0, 1, 16'd0, 16'd0, 4'd0, 16'd2, 16'd7, 4'b1011, 5, 0, 0);
    check("cmp_lt_data", resp_data, 16'd3);

    // Continuous contention, resp_ready held high: expect 0,1,0,1
    for (int i = 0; i < 4; i++)
      run_op(1, 1, 16'(100 + i), 16'(3 + i), 4'b0000, 16'(200 + i), 16'(9 + i), 4'b0101, 0, 1, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("count_after_rr", op_count, 8'd6);

    // Unit routing, one op per unit
    run_op(1, 0, 16'h1234, 16'h00F3, 4'b0000, 16'd0, 16'd0, 4'd0, 1, 0, 0);
    run_op(1, 0, 16'h1234, 16'h00F3, 4'b0100, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    run_op(1, 0, 16'h1234, 16'h00F3, 4'b1000, 16'd0, 16'd0, 4'd0, 2, 0, 0);
    run_op(1, 0, 16'h1234, 16'h00F3, 4'b1100, 16'd0, 16'd0, 4'd0, 0, 1, 0);
    check("shift_data", resp_data, 16'h91A0);

    // Reset during EXEC of a req0 op
    req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd4; req0_fun = 4'b0000;
    @(negedge clock);
    req0_valid = 1'b0;
    check("pre_rst_en", arith_en, 1);
    #2 rest = 1'b0;
    #1;
    check("midrst_en", {shift_en, cmp_en, logic_en, arith_en}, 0);
    check("midrst_rv", resp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", op_count, 0);
    @(negedge clock);
    rest = 1'b1;
    m_last = 1; m_count = 0;
    @(negedge clock);
    // First tie after reset goes to req0
    run_op(1, 1, 16'd11, 16'd22, 4'b0001, 16'd33, 16'd44, 4'b0010, 0, 0, 0);

    // Randomized traffic; total 256 ops since reset wraps the counter
    for (int i = 0; i < 255; i++) begin
      v = $urandom_range(1, 3);
      run_op(v[0], v[1],
             16'($urandom), 16'($urandom), 4'($urandom),
             16'($urandom), 16'($urandom), 4'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end
    check("count_wrap", op_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
